// File: rtl/bus_demux1to4.sv
`timescale 1ns/1ps
// bus_demux1to4: routes one initiator transfer to one of four targets chosen by Addr[13:12].
// Latency: TReq rises one cycle after Req; Ack/Err one cycle after the selected TAck or timeout.
// Backpressure: Req is ignored in BUSY and RESP; a held Req starts the next transfer from IDLE.
module bus_demux1to4 #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        We,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Ack,
  output logic        Err,
  output logic [31:0] RData,
  output logic [3:0]  TReq,
  output logic        TWe,
  output logic [31:0] TAddr,
  output logic [31:0] TWData,
  input  logic [3:0]  TAck,
  input  logic [31:0] TRData0,
  input  logic [31:0] TRData1,
  input  logic [31:0] TRData2,
  input  logic [31:0] TRData3
);

  // Counter only needs to reach TIMEOUT-1: the timeout fires on the edge where it sits there.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic [CW-1:0]   r_cnt;

  logic [1:0]      w_sel;
  logic            w_busy;
  logic            w_tack_sel;
  logic            w_timeout;
  logic [31:0]     w_trdata_sel;

  // Select the addressed target's acknowledge and read data; other targets are never looked at.
  always_comb begin
    w_sel        = r_addr[13:12];
    w_busy       = (r_state == BUSY);
    w_tack_sel   = TAck[w_sel];
    w_timeout    = (r_cnt == CW'(TIMEOUT - 1));
    w_trdata_sel = 32'h0;
    case (w_sel)
      2'd0: w_trdata_sel = TRData0;
      2'd1: w_trdata_sel = TRData1;
      2'd2: w_trdata_sel = TRData2;
      2'd3: w_trdata_sel = TRData3;
      default: w_trdata_sel = 32'h0;
    endcase
  end

  // Next-state logic: acknowledge takes priority over timeout by sharing the same exit to RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Req) w_next = BUSY;
      BUSY:    if (w_tack_sel || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; reset drops straight back to IDLE, which also kills TReq combinationally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Request latch, BUSY cycle counter and the registered completion outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      Ack     <= 1'b0;
      Err     <= 1'b0;
      RData   <= 32'h0;
    end else begin
      // Ack/Err are only ever set for the single RESP cycle.
      Ack <= 1'b0;
      Err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Req) begin
            r_addr  <= Addr;
            r_wdata <= WData;
            r_we    <= We;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (w_tack_sel) begin
            Ack   <= 1'b1;
            RData <= r_we ? 32'h0 : w_trdata_sel;
          end else if (w_timeout) begin
            Err   <= 1'b1;
            RData <= 32'h0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Target-side outputs carry the latched transfer only while BUSY and are zero otherwise.
  always_comb begin
    TReq   = w_busy ? (4'b0001 << w_sel) : 4'b0000;
    TWe    = w_busy ? r_we : 1'b0;
    TAddr  = w_busy ? r_addr : 32'h0;
    TWData = w_busy ? r_wdata : 32'h0;
  end

endmodule
